// File: rtl/video_pkg.sv
// rtl/video_pkg.sv - shared video constants, config types and RGB332 helpers
package video_pkg;

  localparam int NUM_SRC  = 4;
  localparam int SRC_W    = 2;
  localparam int H_ACTIVE = 640;
  localparam int V_ACTIVE = 480;
  localparam int CNT_W    = 12;
  localparam int R_W      = 3;
  localparam int G_W      = 3;
  localparam int B_W      = 2;
  localparam int RGB_W    = R_W + G_W + B_W;

  localparam logic [RGB_W-1:0] BLANK_RGB = 8'h00;

  typedef enum logic {
    IDLE,
    PENDING
  } cfg_state_t;

  typedef struct packed {
    logic [NUM_SRC-1:0]       mask;
    logic [SRC_W*NUM_SRC-1:0] prio;
  } layer_cfg_t;

  // Background only, source 3 highest priority down to source 0
  localparam layer_cfg_t RESET_CFG = '{mask: 4'b0001, prio: 8'h1B};

  function automatic logic [RGB_W-1:0] pick_rgb(
    input logic [R_W*NUM_SRC-1:0] r,
    input logic [G_W*NUM_SRC-1:0] g,
    input logic [B_W*NUM_SRC-1:0] b,
    input logic [SRC_W-1:0]       idx
  );
    return {r[R_W*int'(idx) +: R_W], g[G_W*int'(idx) +: G_W], b[B_W*int'(idx) +: B_W]};
  endfunction

endpackage

// File: rtl/prio_perm_check.sv
// rtl/prio_perm_check.sv - flags whether a priority vector is a permutation of all sources
module prio_perm_check
  import video_pkg::*;
(
  input  logic [SRC_W*NUM_SRC-1:0] prio,
  output logic                     valid
);

  logic [NUM_SRC-1:0] seen;

  // With NUM_SRC slots and NUM_SRC values, every value seen means no duplicates
  always_comb begin
    seen = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      seen[prio[SRC_W*k +: SRC_W]] = 1'b1;
    end
    valid = &seen;
  end

endmodule

// File: rtl/layer_compositor.sv
// rtl/layer_compositor.sv - per-pixel layer arbiter with tear-free configuration update
module layer_compositor
  import video_pkg::*;
(
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic [CNT_W-1:0]         hcount,
  input  logic [CNT_W-1:0]         vcount,
  output logic [NUM_SRC-1:0]       src_enable,
  input  logic [R_W*NUM_SRC-1:0]   src_red,
  input  logic [G_W*NUM_SRC-1:0]   src_green,
  input  logic [B_W*NUM_SRC-1:0]   src_blue,
  input  logic [NUM_SRC-1:0]       src_layer,
  input  logic                     cfg_valid,
  output logic                     cfg_ready,
  input  logic [NUM_SRC-1:0]       cfg_mask,
  input  logic [SRC_W*NUM_SRC-1:0] cfg_prio,
  output logic                     cfg_err,
  output logic [R_W-1:0]           red,
  output logic [G_W-1:0]           green,
  output logic [B_W-1:0]           blue,
  output logic                     pix_active
);

  cfg_state_t       state, state_nxt;
  layer_cfg_t       live_cfg, pend_cfg, pipe_cfg;
  logic             perm_ok;
  logic             active_now, at_boundary;
  logic             capture, apply, err_nxt;
  logic             pipe_act;
  logic             found;
  logic [SRC_W-1:0] sel;
  logic [RGB_W-1:0] win_rgb, rgb_q;

  prio_perm_check u_perm_check (
    .prio  (cfg_prio),
    .valid (perm_ok)
  );

  assign active_now  = (hcount < CNT_W'(H_ACTIVE)) && (vcount < CNT_W'(V_ACTIVE));
  assign at_boundary = (hcount == '0) && (vcount == CNT_W'(V_ACTIVE));
  assign src_enable  = live_cfg.mask & {NUM_SRC{active_now}};
  assign cfg_ready   = (state == IDLE);

  always_ff @(posedge clock) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    capture   = 1'b0;
    apply     = 1'b0;
    err_nxt   = 1'b0;
    case (state)
      IDLE: begin
        if (cfg_valid) begin
          if (perm_ok) begin
            capture   = 1'b1;
            state_nxt = PENDING;
          end else begin
            err_nxt = 1'b1;
          end
        end
      end
      PENDING: begin
        if (at_boundary) begin
          apply     = 1'b1;
          state_nxt = IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      live_cfg <= RESET_CFG;
      pend_cfg <= '0;
      cfg_err  <= 1'b0;
    end else begin
      cfg_err <= err_nxt;
      if (capture) pend_cfg <= {cfg_mask, cfg_prio};
      if (apply)   live_cfg <= pend_cfg;
    end
  end

  // Stage 1: lines up with the sources' own registered output
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      pipe_act <= 1'b0;
      pipe_cfg <= RESET_CFG;
    end else begin
      pipe_act <= active_now;
      pipe_cfg <= live_cfg;
    end
  end

  always_comb begin
    win_rgb = BLANK_RGB;
    found   = 1'b0;
    sel     = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      sel = pipe_cfg.prio[SRC_W*k +: SRC_W];
      if (!found && pipe_cfg.mask[sel] && src_layer[sel]) begin
        found   = 1'b1;
        win_rgb = pick_rgb(src_red, src_green, src_blue, sel);
      end
    end
    // Background fills in when nothing claims the pixel
    if (!found && pipe_cfg.mask[0]) begin
      win_rgb = pick_rgb(src_red, src_green, src_blue, '0);
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      rgb_q      <= BLANK_RGB;
      pix_active <= 1'b0;
    end else begin
      rgb_q      <= pipe_act ? win_rgb : BLANK_RGB;
      pix_active <= pipe_act;
    end
  end

  assign red   = rgb_q[RGB_W-1 -: R_W];
  assign green = rgb_q[B_W +: G_W];
  assign blue  = rgb_q[B_W-1:0];

endmodule

// File: tb/tb_layer_compositor.sv
// tb/tb_layer_compositor.sv - directed and randomized checks of layer_compositor against a frame-level model
module tb_layer_compositor;

  logic        clock = 1'b0;
  logic        reset_n;
  logic [11:0] hcount, vcount;
  logic [3:0]  src_enable;
  logic [11:0] src_red, src_green;
  logic [7:0]  src_blue;
  logic [3:0]  src_layer;
  logic        cfg_valid, cfg_ready;
  logic [3:0]  cfg_mask;
  logic [7:0]  cfg_prio;
  logic        cfg_err;
  logic [2:0]  red, green;
  logic [1:0]  blue;
  logic        pix_active;

  int total = 0;
  int bad   = 0;

  // Model: live/pending config, pixel awaiting its source colours, expected outputs
  bit         m_pend;
  logic [3:0] m_mask, p_mask, r_mask;
  logic [7:0] m_prio, p_prio, r_prio;
  bit         r_act;
  logic [7:0] e_rgb;
  bit         e_pix, e_err;
  bit         e_ok = 1'b0;

  always #5 clock = ~clock;

  layer_compositor dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .hcount     (hcount),
    .vcount     (vcount),
    .src_enable (src_enable),
    .src_red    (src_red),
    .src_green  (src_green),
    .src_blue   (src_blue),
    .src_layer  (src_layer),
    .cfg_valid  (cfg_valid),
    .cfg_ready  (cfg_ready),
    .cfg_mask   (cfg_mask),
    .cfg_prio   (cfg_prio),
    .cfg_err    (cfg_err),
    .red        (red),
    .green      (green),
    .blue       (blue),
    .pix_active (pix_active)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit perm_ok(input logic [7:0] p);
    for (int v = 0; v < 4; v++) begin
      bit hit = 1'b0;
      for (int k = 0; k < 4; k++) if (p[2*k +: 2] == 2'(v)) hit = 1'b1;
      if (!hit) return 1'b0;
    end
    return 1'b1;
  endfunction

  function automatic logic [8:0] compose(input bit act, input logic [3:0] mask, input logic [7:0] prio,
                                         input logic [11:0] r, input logic [11:0] g,
                                         input logic [7:0] b, input logic [3:0] l);
    int s;
    if (!act) return 9'h000;
    for (int k = 0; k < 4; k++) begin
      s = int'(prio[2*k +: 2]);
      if (mask[s] && l[s]) return {1'b1, r[3*s +: 3], g[3*s +: 3], b[2*s +: 2]};
    end
    if (mask[0]) return {1'b1, r[2:0], g[2:0], b[1:0]};
    return {1'b1, 8'h00};
  endfunction

  // Applies the current inputs across one rising edge, then checks at the falling edge
  task automatic step();
    bit         act;
    logic [8:0] c;
    #1;
    act = (hcount < 640) && (vcount < 480);
    if (e_ok && reset_n) chk("src_enable", src_enable, m_mask & {4{act}});
    c = compose(r_act, r_mask, r_prio, src_red, src_green, src_blue, src_layer);
    if (!reset_n) begin
      e_rgb = 8'h00; e_pix = 1'b0; e_err = 1'b0;
      m_pend = 1'b0; m_mask = 4'b0001; m_prio = 8'h1B; p_mask = '0; p_prio = '0;
      r_act = 1'b0; r_mask = 4'b0001; r_prio = 8'h1B;
      e_ok = 1'b1;
    end else begin
      e_rgb = c[7:0];
      e_pix = c[8];
      e_err = !m_pend && cfg_valid && !perm_ok(cfg_prio);
      r_act = act; r_mask = m_mask; r_prio = m_prio;
      if (m_pend) begin
        if (hcount == 0 && vcount == 480) begin
          m_mask = p_mask; m_prio = p_prio; m_pend = 1'b0;
        end
      end else if (cfg_valid && perm_ok(cfg_prio)) begin
        p_mask = cfg_mask; p_prio = cfg_prio; m_pend = 1'b1;
      end
    end
    @(posedge clock);
    @(negedge clock);
    if (e_ok) begin
      chk("rgb", {red, green, blue}, e_rgb);
      chk("pix_active", pix_active, e_pix);
      chk("cfg_err", cfg_err, e_err);
      chk("cfg_ready", cfg_ready, !m_pend);
    end
  endtask

  task automatic set_px(input int h, input int v);
    hcount = 12'(h);
    vcount = 12'(v);
  endtask

  task automatic offer(input logic [3:0] m, input logic [7:0] p);
    cfg_valid = 1'b1; cfg_mask = m; cfg_prio = p;
    step();
    cfg_valid = 1'b0;
  endtask

  initial begin
    int a[4];
    int j, t;
    reset_n = 1'b0; cfg_valid = 1'b0; cfg_mask = '0; cfg_prio = '0;
    set_px(0, 500);
    // src0 = 5/3/2 (8'hAE), src2 = 2/7/1 (8'h5D)
    src_red = {3'd1, 3'd2, 3'd6, 3'd5}; src_green = {3'd4, 3'd7, 3'd0, 3'd3};
    src_blue = {2'd0, 2'd1, 2'd3, 2'd2}; src_layer = 4'b0000;
    step(); step();
    chk("reset_rgb", {red, green, blue}, 8'h00);
    chk("reset_pix", pix_active, 1'b0);
    chk("reset_ready", cfg_ready, 1'b1);
    chk("reset_err", cfg_err, 1'b0);
    reset_n = 1'b1;

    set_px(10, 10); step();
    chk("bg_enable", src_enable, 4'b0001);
    set_px(700, 10); step();
    chk("bg_rgb", {red, green, blue}, 8'hAE);
    chk("bg_pix", pix_active, 1'b1);

    offer(4'b1111, 8'h36);
    chk("pend_ready", cfg_ready, 1'b0);
    src_layer = 4'b0110;
    set_px(20, 20); step(); step();
    chk("pre_boundary_rgb", {red, green, blue}, 8'hAE);
    chk("pre_boundary_ready", cfg_ready, 1'b0);
    set_px(0, 480); step();
    chk("post_boundary_ready", cfg_ready, 1'b1);
    set_px(20, 20); step();
    chk("new_enable", src_enable, 4'b1111);
    step();
    chk("new_rgb", {red, green, blue}, 8'h5D);

    offer(4'b0011, 8'h25);
    chk("err_pulse", cfg_err, 1'b1);
    chk("err_ready", cfg_ready, 1'b1);
    step();
    chk("err_end", cfg_err, 1'b0);
    chk("err_live_kept", src_enable, 4'b1111);

    set_px(640, 20); step();
    chk("h_edge_enable", src_enable, 4'b0000);
    set_px(20, 480); step();
    chk("v_edge_enable", src_enable, 4'b0000);
    chk("h_edge_rgb", {red, green, blue}, 8'h00);
    chk("h_edge_pix", pix_active, 1'b0);

    set_px(700, 10);
    offer(4'b1110, 8'h1B);
    offer(4'b0100, 8'hE4);
    chk("pend_ignored_ready", cfg_ready, 1'b0);
    reset_n = 1'b0; step(); reset_n = 1'b1;
    set_px(20, 20); step();
    chk("rst_pend_enable", src_enable, 4'b0001);
    chk("rst_pend_ready", cfg_ready, 1'b1);

    set_px(700, 10);
    offer(4'b1110, 8'h1B);
    set_px(0, 480); step();
    src_layer = 4'b0000;
    set_px(20, 20); step();
    chk("nobg_enable", src_enable, 4'b1110);
    set_px(700, 10); step();
    chk("nobg_rgb", {red, green, blue}, 8'h00);
    chk("nobg_pix", pix_active, 1'b1);

    for (int n = 0; n < 4000; n++) begin
      case ($urandom_range(0, 7))
        0:       set_px(0, 480);
        1:       set_px($urandom_range(636, 644), $urandom_range(476, 484));
        default: set_px($urandom_range(0, 799), $urandom_range(0, 524));
      endcase
      src_red = 12'($urandom); src_green = 12'($urandom);
      src_blue = 8'($urandom); src_layer = 4'($urandom);
      reset_n = ($urandom_range(0, 499) != 0);
      cfg_valid = ($urandom_range(0, 5) == 0);
      cfg_mask = 4'($urandom);
      if ($urandom_range(0, 1) == 0) begin
        cfg_prio = 8'($urandom);
      end else begin
        a = '{0, 1, 2, 3};
        for (int i = 3; i > 0; i--) begin
          j = $urandom_range(0, i);
          t = a[i]; a[i] = a[j]; a[j] = t;
        end
        cfg_prio = {2'(a[3]), 2'(a[2]), 2'(a[1]), 2'(a[0])};
      end
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
